// File: rtl/mem_port_responder.sv
// MemPort responder: word-addressed local RAM with byte-enable writes and programmable grant wait states.
// Optional MEM_RESP_ERR_EN: registered one-cycle err pulse after an out-of-range grant.
module mem_port_responder #(
    parameter int unsigned      ABITS       = 32,
    parameter logic [ABITS-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned      DEPTH       = 1024,
    parameter int unsigned      WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [ABITS-1:0] mem_addr,
    input  logic             mem_write_en,
    input  logic [3:0]       mem_byte_en,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    output logic             err
);

    localparam int unsigned      IW      = $clog2(DEPTH);
    localparam logic [ABITS-1:0] DEPTH_W = ABITS'(DEPTH);

    logic [31:0]      storage [DEPTH];
    logic [ABITS-1:0] offset;
    logic [ABITS-1:0] index;
    logic [IW-1:0]    word_idx;
    logic             in_range;
    logic             grant;

    // Subtraction wraps below BASE_ADDR, so the lower-bound test is kept separate.
    assign offset   = mem_addr - BASE_ADDR;
    assign index    = offset >> 2;
    assign word_idx = index[IW-1:0];
    assign in_range = (mem_addr >= BASE_ADDR) && (index < DEPTH_W);
    assign grant    = mem_valid & mem_ready;

    if (WAIT_STATES == 0) begin : g_no_wait
        assign mem_ready = mem_valid;
    end else begin : g_wait
        typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} state_t;

        localparam logic [3:0] RELOAD = 4'(WAIT_STATES - 1);

        state_t     state, state_next;
        logic [3:0] cnt, cnt_next;
        logic       ready_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                cnt     <= '0;
                ready_q <= 1'b0;
            end else begin
                state   <= state_next;
                cnt     <= cnt_next;
                ready_q <= (state_next == S_GRANT);
            end
        end

        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        if (WAIT_STATES == 1) begin
                            state_next = S_GRANT;
                        end else begin
                            state_next = S_WAIT;
                            cnt_next   = RELOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_valid) begin
                        state_next = S_IDLE;
                    end else if (cnt == '0) begin
                        state_next = S_GRANT;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                S_GRANT: begin
                    if (mem_valid) begin
                        state_next = S_WAIT;
                        cnt_next   = RELOAD;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        assign mem_ready = ready_q;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (grant && mem_write_en && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_byte_en[i]) begin
                    storage[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= '0;
        end else if (grant && !mem_write_en) begin
            mem_rdata <= in_range ? storage[word_idx] : 32'hDEAD_BEEF;
        end
    end

`ifdef MEM_RESP_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= grant && !in_range;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder: zero-wait instance and 3-wait-state instance side by side.
`timescale 1ns/1ps
module tb_mem_port_responder;

    localparam bit ERR_EN =
`ifdef MEM_RESP_ERR_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v0 = 1'b0, we0 = 1'b0, r0, e0;
    logic [31:0] a0 = '0, wd0 = '0, rd0;
    logic [3:0]  be0 = '0;

    logic        v3 = 1'b0, we3 = 1'b0, r3, e3;
    logic [31:0] a3 = '0, wd3 = '0, rd3;
    logic [3:0]  be3 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .mem_valid(v0), .mem_ready(r0), .mem_addr(a0),
        .mem_write_en(we0), .mem_byte_en(be0), .mem_wdata(wd0), .mem_rdata(rd0), .err(e0)
    );

    mem_port_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .mem_valid(v3), .mem_ready(r3), .mem_addr(a3),
        .mem_write_en(we3), .mem_byte_en(be3), .mem_wdata(wd3), .mem_rdata(rd3), .err(e3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait access: valid held across exactly one edge.
    task automatic ws0_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
        v0 = 1'b1; a0 = addr; we0 = we; be0 = be; wd0 = wd;
        tick();
        v0 = 1'b0;
    endtask

    // Wait-state access, bounded; ok reports whether a grant was seen.
    task automatic ws3_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wd, output bit ok);
        ok = 1'b0;
        v3 = 1'b1; a3 = addr; we3 = we; be3 = be; wd3 = wd;
        for (int i = 0; i < 12 && !ok; i++) begin
            tick();
            if (r3 === 1'b1) ok = 1'b1;
        end
        if (ok) tick();
        v3 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", r0); end
        n_checks++; if (r3 !== 1'b0) begin n_fail++; $display("FAIL reset_ready3: got %b expected 0", r3); end
        n_checks++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 00000000", rd0); end
        n_checks++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata3: got %h expected 00000000", rd3); end
        n_checks++; if (e0 !== 1'b0 || e3 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", e0, e3); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        v0 = 1'b1; we0 = 1'b1; a0 = 32'h1000_0000; be0 = 4'hF; wd0 = 32'hCAFE_F00D;
        #1;
        n_checks++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_write: got %b expected 1", r0); end
        tick();
        we0 = 1'b0;
        #1;
        n_checks++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_read: got %b expected 1", r0); end
        n_checks++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rdata_after_write: got %h expected 00000000", rd0); end
        tick();
        v0 = 1'b0;
        #1;
        n_checks++; if (rd0 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_rdata: got %h expected cafef00d", rd0); end
        n_checks++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL ready_follows_valid: got %b expected 0", r0); end
    endtask

    task automatic test_byte_enables();
        ws0_op(32'h1000_0004, 1'b1, 4'hF, 32'h1122_3344);
        ws0_op(32'h1000_0004, 1'b1, 4'b0101, 32'hAABB_CCDD);
        ws0_op(32'h1000_0004, 1'b0, 4'h0, 32'h0);
        n_checks++; if (rd0 !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_en_merge: got %h expected 11bb33dd", rd0); end
        ws0_op(32'h1000_0004, 1'b1, 4'h0, 32'hFFFF_FFFF);
        ws0_op(32'h1000_0004, 1'b0, 4'h0, 32'h0);
        n_checks++; if (rd0 !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_en_zero: got %h expected 11bb33dd", rd0); end
    endtask

    task automatic test_out_of_range();
        ws0_op(32'h1000_0FFC, 1'b1, 4'hF, 32'h600D_CAFE);
        n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL err_in_range: got %b expected 0", e0); end
        ws0_op(32'h0FFF_FFFC, 1'b0, 4'h0, 32'h0);
        n_checks++; if (rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oor_low_rdata: got %h expected deadbeef", rd0); end
        n_checks++; if (e0 !== ERR_EN) begin n_fail++; $display("FAIL oor_low_err: got %b expected %b", e0, ERR_EN); end
        tick();
        n_checks++; if (e0 !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", e0); end
        n_checks++; if (rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_hold_idle: got %h expected deadbeef", rd0); end
        ws0_op(32'h1000_0000, 1'b0, 4'h0, 32'h0);
        n_checks++; if (rd0 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL word0_read: got %h expected cafef00d", rd0); end
        ws0_op(32'h1000_1000, 1'b0, 4'h0, 32'h0);
        n_checks++; if (rd0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oor_high_rdata: got %h expected deadbeef", rd0); end
        n_checks++; if (e0 !== ERR_EN) begin n_fail++; $display("FAIL oor_high_err: got %b expected %b", e0, ERR_EN); end
        ws0_op(32'h1000_1000, 1'b1, 4'hF, 32'h0);
        n_checks++; if (e0 !== ERR_EN) begin n_fail++; $display("FAIL oor_write_err: got %b expected %b", e0, ERR_EN); end
        ws0_op(32'h0FFF_FFFC, 1'b1, 4'hF, 32'h0);
        ws0_op(32'h1000_0000, 1'b0, 4'h0, 32'h0);
        n_checks++; if (rd0 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oor_write_word0: got %h expected cafef00d", rd0); end
        ws0_op(32'h1000_0FFC, 1'b0, 4'h0, 32'h0);
        n_checks++; if (rd0 !== 32'h600D_CAFE) begin n_fail++; $display("FAIL oor_write_last: got %h expected 600dcafe", rd0); end
    endtask

    task automatic test_wait_states();
        bit ok;
        v3 = 1'b1; we3 = 1'b1; a3 = 32'h1000_0008; be3 = 4'hF; wd3 = 32'h5555_AAAA;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (r3 !== (k == 4 || k == 8)) begin
                n_fail++; $display("FAIL ws3_ready_cycle%0d: got %b expected %b", k, r3, (k == 4 || k == 8));
            end
        end
        tick();
        v3 = 1'b0;
        tick();
        tick();
        ws3_access(32'h1000_0008, 1'b0, 4'h0, 32'h0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ws3_read_grant: got no ready expected ready"); end
        n_checks++; if (rd3 !== 32'h5555_AAAA) begin n_fail++; $display("FAIL ws3_rdata: got %h expected 5555aaaa", rd3); end
    endtask

    task automatic test_abort();
        bit ok;
        bit saw_ready = 1'b0;
        v3 = 1'b1; we3 = 1'b1; a3 = 32'h1000_0008; be3 = 4'hF; wd3 = 32'h1234_5678;
        tick();
        v3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (r3 !== 1'b0) saw_ready = 1'b1;
            tick();
        end
        n_checks++; if (saw_ready) begin n_fail++; $display("FAIL abort_ready: got ready expected none"); end
        ws3_access(32'h1000_0008, 1'b0, 4'h0, 32'h0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_read_grant: got no ready expected ready"); end
        n_checks++; if (rd3 !== 32'h5555_AAAA) begin n_fail++; $display("FAIL abort_rdata: got %h expected 5555aaaa", rd3); end
    endtask

    task automatic test_async_reset();
        int first = 0;
        v3 = 1'b1; we3 = 1'b1; a3 = 32'h1000_0008; be3 = 4'hF; wd3 = 32'h0BAD_BEEF;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (r3 !== 1'b0) begin n_fail++; $display("FAIL areset_ready: got %b expected 0", r3); end
        n_checks++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL areset_rdata3: got %h expected 00000000", rd3); end
        n_checks++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL areset_rdata0: got %h expected 00000000", rd0); end
        n_checks++; if (e3 !== 1'b0) begin n_fail++; $display("FAIL areset_err: got %b expected 0", e3); end
        v3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        v3 = 1'b1; we3 = 1'b0;
        for (int k = 1; k <= 8 && first == 0; k++) begin
            tick();
            if (r3 === 1'b1) first = k;
        end
        n_checks++; if (first != 4) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 4", first); end
        tick();
        v3 = 1'b0;
        n_checks++; if (rd3 !== 32'h5555_AAAA) begin n_fail++; $display("FAIL areset_no_write: got %h expected 5555aaaa", rd3); end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_enables();
        test_out_of_range();
        test_wait_states();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
